sample_capture_fifo: RTL and testbench
======================================

Name: sample_capture_fifo

Overview:
- Downstream consumer of an 8-bit registered data stage (register output q, updated every posedge clk).
- Samples the stage output on each clock edge while capture is enabled and buffers samples in a small FIFO.
- FIFO drains through a first-word-fall-through valid/ready port.
- Optional change-only mode; overflow flag and drop counter for bench-side checking of driven/sampled sequences.

Parameters:
- WIDTH, 8, data width of sampled stream.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ONLY_CHANGES, 0, 1 = push only when sample differs from last pushed sample.
- CNTW, 8, drop counter width.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- cap_en  input  1  capture enable, sampled at posedge.
- din  input  WIDTH  data from upstream register stage.
- dout  output  WIDTH  FIFO head; 0 when empty.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts head this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky: a sample was dropped.
- clr_ovf  input  1  clears overflow and drop_cnt.
- drop_cnt  output  CNTW  dropped samples, saturating.

Behaviour:
- Reset: rst=1 at posedge clears wr/rd pointers, count=0, dout_valid=0, dout=0, overflow=0, drop_cnt=0, change-history valid bit=0.
- rst has priority over every other input in the same cycle. Mid-operation reset discards all contents and pending push/pop.
- Push candidate: cap_en=1 at posedge.
  - ONLY_CHANGES=0: every candidate is a push request.
  - ONLY_CHANGES=1: request only if history invalid or din != last pushed value.
  - History updates only on an accepted push.
  - History is invalidated by rst and by cap_en going 0.
- Pop: dout_valid && dout_ready at posedge. dout_ready while empty has no effect.
- Push acceptance:
  - Accepted if count<DEPTH.
  - Also accepted if count==DEPTH with a pop in the same cycle; count stays DEPTH, no drop.
- Drop: request while full with no pop.
  - Sample discarded; contents unchanged.
  - overflow<=1.
  - drop_cnt increments, saturating at 2^CNTW-1.
- clr_ovf=1: overflow<=0 and drop_cnt<=0. A drop in the same cycle wins: overflow=1, drop_cnt=1.
- Occupancy:
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- Latency: sample taken at edge N into an empty FIFO gives dout=din(N) and dout_valid=1 from just after edge N, i.e. visible at edge N+1.
- Outputs are registered or decoded from registered state only; no combinational path din->dout or dout_ready->dout_valid.
- Simultaneous push and pop on empty FIFO: pop ignored (not valid), push accepted.
- dout holds stable while dout_valid=1 and dout_ready=0.

Test Plan:
- Reset then cap_en=1 for 3 cycles with din=1,2,3, dout_ready=0 -> count=3, dout=1, dout_valid=1, overflow=0.
- Then dout_ready=1, cap_en=0 -> dout sequence 1,2,3 on consecutive edges, then dout_valid=0, dout=0, count=0.
- DEPTH=8, cap_en=1 for 10 cycles with din=0..9, dout_ready=0 -> count=8, head=0, overflow=1, drop_cnt=2. Then clr_ovf pulse -> overflow=0, drop_cnt=0.
- Full FIFO, cap_en=1, dout_ready=1 for 4 cycles with din=0xA0..0xA3 -> no drops, count stays 8, popped values 0..3, tail ends 0xA0..0xA3.
- ONLY_CHANGES=1, din=5,5,5,7,7,5 with cap_en=1 -> pushes 5,7,5 (count=3). cap_en 0 for one cycle, then din=5 -> 5 pushed again (count=4).
- Push 4 entries, assert rst for one cycle while cap_en=1 and dout_ready=1 -> next cycle count=0, dout_valid=0, dout=0, overflow=0. Capture resumes on the following edge.

Source files
------------

// File: rtl/sample_capture_fifo_if.sv
// Capture FIFO bus: sampling controls, FWFT drain port and overflow status.
interface sample_capture_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
);
    logic                       cap_en;
    logic [WIDTH-1:0]           din;
    logic [WIDTH-1:0]           dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic                       clr_ovf;
    logic [CNTW-1:0]            drop_cnt;

    // Producer/consumer side (drives stimulus, reads status).
    modport master (
        output cap_en, din, dout_ready, clr_ovf,
        input  dout, dout_valid, count, overflow, drop_cnt
    );

    // FIFO side.
    modport slave (
        input  cap_en, din, dout_ready, clr_ovf,
        output dout, dout_valid, count, overflow, drop_cnt
    );
endinterface

// File: rtl/sample_capture_fifo.sv
// Samples an upstream register stage while capture is enabled and buffers the
// samples in a small first-word-fall-through FIFO with overflow accounting.
module sample_capture_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int ONLY_CHANGES = 0,
    parameter int CNTW         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sample_capture_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [CNTW-1:0]  drop_cnt;
    logic [WIDTH-1:0] hist;
    logic             hist_vld;

    logic empty;
    logic full;
    logic req;
    logic pop;
    logic push;
    logic drop;

    // Push/pop/drop decisions for the coming edge.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        req   = bus.cap_en;
        if (ONLY_CHANGES != 0 && hist_vld && bus.din == hist) begin
            req = 1'b0;
        end
        pop  = !empty && bus.dout_ready;
        // A pop on a full FIFO frees the slot the new sample takes.
        push = req && (!full || pop);
        drop = req && full && !pop;
    end

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointers, occupancy, change history and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            hist     <= '0;
            hist_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (!bus.cap_en) begin
                hist_vld <= 1'b0;
            end else if (push) begin
                hist_vld <= 1'b1;
                hist     <= bus.din;
            end

            // A drop in the same cycle as a clear restarts the tally at one.
            if (drop) begin
                overflow <= 1'b1;
                if (bus.clr_ovf)           drop_cnt <= CNTW'(1);
                else if (drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
            end else if (bus.clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Outputs decoded from registered state only.
    assign bus.dout       = empty ? '0 : mem[rd_ptr];
    assign bus.dout_valid = !empty;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_sample_capture_fifo.sv
// Directed bench: one FIFO in plain capture mode, one in change-only mode.
module tb_sample_capture_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sample_capture_fifo_if #(.WIDTH(8), .DEPTH(8), .CNTW(8)) ia ();
    sample_capture_fifo_if #(.WIDTH(8), .DEPTH(8), .CNTW(8)) ic ();

    sample_capture_fifo #(.WIDTH(8), .DEPTH(8), .ONLY_CHANGES(0), .CNTW(8)) u_all (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );

    sample_capture_fifo #(.WIDTH(8), .DEPTH(8), .ONLY_CHANGES(1), .CNTW(8)) u_chg (
        .clk(clk), .rst(rst), .bus(ic.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        logic [7:0] chg_in [6];
        logic [7:0] chg_out [4];
        checks = 0;
        errors = 0;

        rst = 1'b1;
        ia.cap_en = 0; ia.din = 0; ia.dout_ready = 0; ia.clr_ovf = 0;
        ic.cap_en = 0; ic.din = 0; ic.dout_ready = 0; ic.clr_ovf = 0;
        step();
        step();
        rst = 1'b0;

        chk("rst_count", 32'(ia.count), 0);
        chk("rst_valid", 32'(ia.dout_valid), 0);
        chk("rst_dout", 32'(ia.dout), 0);
        chk("rst_ovf", 32'(ia.overflow), 0);
        chk("rst_drop", 32'(ia.drop_cnt), 0);

        // Three samples, no consumer.
        ia.cap_en = 1;
        for (int i = 1; i <= 3; i++) begin
            ia.din = 8'(i);
            step();
            if (i == 1) begin
                chk("lat_valid", 32'(ia.dout_valid), 1);
                chk("lat_dout", 32'(ia.dout), 1);
            end
        end
        ia.cap_en = 0;
        chk("t1_count", 32'(ia.count), 3);
        chk("t1_dout", 32'(ia.dout), 1);
        chk("t1_valid", 32'(ia.dout_valid), 1);
        chk("t1_ovf", 32'(ia.overflow), 0);

        // Drain in order.
        ia.dout_ready = 1;
        step();
        chk("t2_dout2", 32'(ia.dout), 2);
        step();
        chk("t2_dout3", 32'(ia.dout), 3);
        step();
        chk("t2_valid", 32'(ia.dout_valid), 0);
        chk("t2_dout0", 32'(ia.dout), 0);
        chk("t2_count", 32'(ia.count), 0);
        ia.dout_ready = 0;
        step();
        chk("t2_idle_count", 32'(ia.count), 0);

        // Ten samples into eight entries.
        ia.cap_en = 1;
        for (int i = 0; i < 10; i++) begin
            ia.din = 8'(i);
            step();
            if (i == 7) begin
                chk("t3_full_count", 32'(ia.count), 8);
                chk("t3_full_noovf", 32'(ia.overflow), 0);
            end
        end
        ia.cap_en = 0;
        chk("t3_count", 32'(ia.count), 8);
        chk("t3_head", 32'(ia.dout), 0);
        chk("t3_ovf", 32'(ia.overflow), 1);
        chk("t3_drop", 32'(ia.drop_cnt), 2);

        // Clear together with a new drop: the drop wins.
        ia.cap_en = 1; ia.din = 8'h55; ia.clr_ovf = 1;
        step();
        ia.cap_en = 0;
        chk("clrdrop_ovf", 32'(ia.overflow), 1);
        chk("clrdrop_cnt", 32'(ia.drop_cnt), 1);
        chk("clrdrop_count", 32'(ia.count), 8);
        step();
        ia.clr_ovf = 0;
        chk("clr_ovf", 32'(ia.overflow), 0);
        chk("clr_drop", 32'(ia.drop_cnt), 0);
        chk("clr_head", 32'(ia.dout), 0);

        // Full FIFO with simultaneous push and pop.
        ia.cap_en = 1; ia.dout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ia.din = 8'hA0 + 8'(i);
            chk("t4_pop", 32'(ia.dout), 32'(i));
            step();
            chk("t4_count", 32'(ia.count), 8);
        end
        ia.cap_en = 0;
        chk("t4_drop", 32'(ia.drop_cnt), 0);
        chk("t4_ovf", 32'(ia.overflow), 0);
        exp_seq[0] = 8'h04; exp_seq[1] = 8'h05; exp_seq[2] = 8'h06; exp_seq[3] = 8'h07;
        exp_seq[4] = 8'hA0; exp_seq[5] = 8'hA1; exp_seq[6] = 8'hA2; exp_seq[7] = 8'hA3;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain", 32'(ia.dout), 32'(exp_seq[i]));
            step();
        end
        chk("t4_empty", 32'(ia.dout_valid), 0);
        ia.dout_ready = 0;

        // Change-only capture.
        chg_in[0] = 5; chg_in[1] = 5; chg_in[2] = 5; chg_in[3] = 7; chg_in[4] = 7; chg_in[5] = 5;
        ic.cap_en = 1;
        for (int i = 0; i < 6; i++) begin
            ic.din = chg_in[i];
            step();
        end
        chk("t5_count3", 32'(ic.count), 3);
        ic.cap_en = 0;
        step();
        ic.cap_en = 1; ic.din = 5;
        step();
        ic.cap_en = 0;
        chk("t5_count4", 32'(ic.count), 4);
        chg_out[0] = 5; chg_out[1] = 7; chg_out[2] = 5; chg_out[3] = 5;
        ic.dout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain", 32'(ic.dout), 32'(chg_out[i]));
            step();
        end
        chk("t5_empty", 32'(ic.dout_valid), 0);
        ic.dout_ready = 0;

        // Mid-operation reset.
        ia.cap_en = 1;
        for (int i = 0; i < 4; i++) begin
            ia.din = 8'h10 + 8'(i);
            step();
        end
        chk("t6_count4", 32'(ia.count), 4);
        rst = 1; ia.din = 8'h14; ia.dout_ready = 1;
        step();
        rst = 0;
        chk("t6_count0", 32'(ia.count), 0);
        chk("t6_valid", 32'(ia.dout_valid), 0);
        chk("t6_dout", 32'(ia.dout), 0);
        chk("t6_ovf", 32'(ia.overflow), 0);
        // Resume on an empty FIFO with the consumer ready: push kept, pop ignored.
        ia.din = 8'h15;
        step();
        ia.cap_en = 0; ia.dout_ready = 0;
        chk("t6_resume_count", 32'(ia.count), 1);
        chk("t6_resume_dout", 32'(ia.dout), 32'h15);
        chk("t6_resume_valid", 32'(ia.dout_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
